// File: rtl/copperv_pkg.sv
// Shared types and constants for the copperv data-bus target.
package copperv_pkg;

    localparam int BUS_ADDR_W              = 32;
    localparam int BUS_DATA_W              = 32;
    localparam int MEM_RSP_LATENCY_DEFAULT = 1;

    // CLEAR zero-fills the memory after reset; SERVE answers bus commands.
    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_SERVE = 1'b1
    } mem_state_e;

    // True when a word index falls inside a memory of 'words' entries.
    function automatic logic word_in_range(input logic [BUS_ADDR_W-3:0] idx,
                                           input int words);
        return 32'(idx) < 32'(words);
    endfunction

endpackage

// File: rtl/bus_rsp_pipe.sv
// Fixed-latency response delay line. Stage 0 captures the response at the
// command-acceptance edge; the last stage drives the bus response outputs.
// Data is forced to zero whenever the stage holds no response, so the
// outputs read 0 outside of a ready pulse.
module bus_rsp_pipe #(
    parameter int LATENCY = 1,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_rdata,
    output logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata
);

    logic [LATENCY-1:0]             valid_reg;
    logic [LATENCY-1:0][DATA_W-1:0] data_reg;
    logic [LATENCY-1:0]             stage_valid_w;
    logic [LATENCY-1:0][DATA_W-1:0] stage_data_w;

    // Each stage loads from the one before it; stage 0 loads the new response.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign stage_valid_w[gi] = in_valid;
            assign stage_data_w[gi]  = in_valid ? in_rdata : '0;
        end else begin : g_body
            assign stage_valid_w[gi] = valid_reg[gi-1];
            assign stage_data_w[gi]  = data_reg[gi-1];
        end
    end

    // Shift all stages; reset flushes any in-flight responses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= '0;
            data_reg  <= '0;
        end else begin
            valid_reg <= stage_valid_w;
            data_reg  <= stage_data_w;
        end
    end

    assign rsp_ready = valid_reg[LATENCY-1];
    assign rsp_rdata = data_reg[LATENCY-1];

endmodule

// File: rtl/bus_mem_responder.sv
// Data-bus target: word-addressed memory that is zero-filled after reset,
// then executes one read or write per cycle and answers each accepted
// command with a single ready pulse after LATENCY cycles.
module bus_mem_responder
    import copperv_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = MEM_RSP_LATENCY_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [BUS_ADDR_W-1:0] bus_cmd_addr,
    input  logic [BUS_DATA_W-1:0] bus_cmd_wdata,
    input  logic                  bus_cmd_en,
    input  logic                  bus_cmd_we,
    output logic [BUS_DATA_W-1:0] bus_rsp_rdata,
    output logic                  bus_rsp_ready,
    output logic                  init_done,
    output logic                  err_dropped,
    output logic                  err_range
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [BUS_DATA_W-1:0] mem [MEM_WORDS];

    mem_state_e state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic err_dropped_reg, err_dropped_next;
    logic err_range_reg, err_range_next;

    logic [BUS_ADDR_W-3:0] word_idx;
    logic [AW-1:0]         cmd_word;
    logic                  cmd_in_range;
    logic                  unused_addr_lsbs;

    logic                  mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [BUS_DATA_W-1:0] mem_wdata;
    logic                  rsp_valid;
    logic [BUS_DATA_W-1:0] rsp_rdata;

    // Byte address to word index; the two byte-lane bits carry no meaning.
    assign word_idx         = bus_cmd_addr[BUS_ADDR_W-1:2];
    assign cmd_word         = word_idx[AW-1:0];
    assign cmd_in_range     = word_in_range(word_idx, MEM_WORDS);
    assign unused_addr_lsbs = ^bus_cmd_addr[1:0];

    // State, clear counter and sticky error flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= MEM_CLEAR;
            cnt_reg         <= '0;
            err_dropped_reg <= 1'b0;
            err_range_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            err_dropped_reg <= err_dropped_next;
            err_range_reg   <= err_range_next;
        end
    end

    // Next state, memory write port and the response handed to the pipe.
    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        err_dropped_next = err_dropped_reg;
        err_range_next   = err_range_reg;
        mem_we           = 1'b0;
        mem_waddr        = cmd_word;
        mem_wdata        = bus_cmd_wdata;
        rsp_valid        = 1'b0;
        rsp_rdata        = '0;

        case (state_reg)
            MEM_CLEAR: begin
                // One word zeroed per cycle; commands are refused meanwhile.
                mem_we    = 1'b1;
                mem_waddr = cnt_reg;
                mem_wdata = '0;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == AW'(MEM_WORDS - 1)) begin
                    state_next = MEM_SERVE;
                end
                if (bus_cmd_en) begin
                    err_dropped_next = 1'b1;
                end
            end
            MEM_SERVE: begin
                if (bus_cmd_en) begin
                    // Every accepted command gets a response, even out of range.
                    rsp_valid = 1'b1;
                    if (cmd_in_range) begin
                        if (bus_cmd_we) begin
                            mem_we = 1'b1;
                        end else begin
                            // Value before this edge's write is the read result.
                            rsp_rdata = mem[cmd_word];
                        end
                    end else begin
                        err_range_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = MEM_CLEAR;
            end
        endcase
    end

    // Single write port shared by the clear sweep and bus writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    bus_rsp_pipe #(
        .LATENCY (LATENCY),
        .DATA_W  (BUS_DATA_W)
    ) u_rsp_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rsp_valid),
        .in_rdata  (rsp_rdata),
        .rsp_ready (bus_rsp_ready),
        .rsp_rdata (bus_rsp_rdata)
    );

    assign init_done   = (state_reg == MEM_SERVE);
    assign err_dropped = err_dropped_reg;
    assign err_range   = err_range_reg;

endmodule

// File: doc/bus_mem_responder.md
# bus_mem_responder

Bus target that answers the core's data-bus command interface (bus_cmd_* / bus_rsp_*).
- Holds a word-addressed on-chip memory, zero-cleared after every reset.
- Executes each accepted read or write in order.
- Returns exactly one bus_rsp_ready pulse per command after a fixed LATENCY.
- Sits opposite the execution unit's bus master port and serves as the data-memory model/target in simulation and small FPGA builds.

## Interface
Parameters:
- MEM_WORDS, 1024: number of 32-bit words; power of two, ≥ 4.
- LATENCY, 1: cycles from command acceptance to response; ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- bus_cmd_addr  in  32  byte address; bits [1:0] ignored.
- bus_cmd_wdata  in  32  write data; used only when bus_cmd_we=1.
- bus_cmd_en  in  1  command valid for this cycle; no back-pressure.
- bus_cmd_we  in  1  1 = write, 0 = read.
- bus_rsp_rdata  out  32  read data; valid only while bus_rsp_ready=1, otherwise 0.
- bus_rsp_ready  out  1  one-cycle response pulse per accepted command.
- init_done  out  1  memory clear finished; commands accepted only while high.
- err_dropped  out  1  sticky: a command arrived while init_done=0.
- err_range  out  1  sticky: an accepted command addressed a word ≥ MEM_WORDS.

## Operation
- FSM, two states: CLEAR and SERVE.
- Reset enters CLEAR with word counter = 0.
- CLEAR:
  - Writes 0 to word[counter] each cycle and increments the counter.
  - After word MEM_WORDS-1 is written, moves to SERVE. init_done is 1 in the following cycle and stays 1 until reset.
- bus_cmd_en=1 in CLEAR: command dropped, no response, err_dropped set.
- SERVE: accepts every cycle with bus_cmd_en=1.
  - Word index = bus_cmd_addr[31:2].
  - In range (index < MEM_WORDS):
    - Write updates the word at the acceptance edge.
    - Read captures the word's value as it stood before that edge.
  - Out of range: write discarded, read returns 0, err_range set. A response is still issued.
  - Write response: bus_rsp_ready pulse with bus_rsp_rdata = 0.
- Responses are strictly in command order and never merge. With at most one command per cycle and fixed latency, at most one response per cycle.
- err_dropped and err_range are cleared only by reset.

## Timing
- Reset values: bus_rsp_rdata=0, bus_rsp_ready=0, init_done=0, err_dropped=0, err_range=0. The response pipeline is emptied.
- Reset asserted mid-operation: pending responses are discarded (no pulse after reset release). Memory is re-cleared from word 0.
- Clear phase: init_done rises MEM_WORDS cycles after the first rising edge with rstn=1.
- Command presented in cycle N (en=1 at edge N) gives bus_rsp_ready=1 in cycle N+LATENCY, for exactly one cycle.
- Back-to-back commands in cycles N, N+1, … give responses in consecutive cycles N+LATENCY, N+1+LATENCY, …
- Write in cycle N, read of the same word in cycle N+1: the read returns the new data.
- A command in the cycle of the CLEAR→SERVE transition (init_done still 0) is dropped.
- Error flags assert in the cycle after the offending edge.

## Structure
- copperv_pkg gains:
  - mem_state_e {MEM_CLEAR, MEM_SERVE};
  - localparam BUS_ADDR_W=32, BUS_DATA_W=32;
  - localparam MEM_RSP_LATENCY_DEFAULT=1.
- Sub-module bus_rsp_pipe, parameterised by LATENCY:
  - LATENCY-stage shift register of {valid, rdata};
  - flushed to zero by reset;
  - its last stage drives bus_rsp_ready/bus_rsp_rdata.
- Memory array, FSM and error flags live in the top module.

## Test plan
- Reset, then idle, MEM_WORDS=16: init_done rises exactly 16 cycles after rstn release. All outputs 0 until then; a read of 0x0 then returns 0x00000000.
- Write 0x0000_0004←0xCAFEBABE in cycle N, read 0x4 in cycle N+1, LATENCY=2: ready pulses at N+2 (rdata 0) and N+3 (rdata 0xCAFEBABE).
- Eight back-to-back reads of pre-written words 0..7 (value = index·0x11): eight consecutive ready pulses with rdata 0x00,0x11,…,0x77 in order.
- Command with en=1 during CLEAR: no ready pulse; err_dropped=1 and stays 1 through later traffic.
- Read addr 0x40 with MEM_WORDS=16: ready pulse with rdata 0, err_range=1. A write to 0x40 leaves words 0..15 unchanged.
- Read issued, rstn pulsed low before the response cycle: no ready pulse after release; init_done re-clears; the previously written word reads 0.
